// File: rtl/aes_pkg.sv
// +-----------------------------------------------------------------------+
// | aes_pkg : AES-128 key-schedule constants, FSM state type, word helpers |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
`default_nettype none

package aes_pkg;

    localparam int NR = 10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } ks_state_e;

    function automatic logic [7:0] rcon(input logic [3:0] round);
        logic [7:0] r;
        case (round)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] xor_word(input logic [31:0] a, input logic [31:0] b);
        return a ^ b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/inv_key_schedule_sbox.sv
// +-----------------------------------------------------------------------+
// | S_Box : AES forward S-box, single byte, purely combinational          |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
`default_nettype none

module S_Box (
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte, so byte x starts at bit 8*(255-x) = {~x,3'b0}.
    logic [10:0] w_base;
    assign w_base = {~data_i, 3'b000};
    assign data_o = c_SBOX[w_base +: 8];

endmodule

`default_nettype wire

// File: rtl/inv_key_schedule.sv
// +-----------------------------------------------------------------------+
// | inv_key_schedule : iterative AES-128 inverse key expander, 10 -> 0    |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
`default_nettype none

module inv_key_schedule
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         kin_valid,
    output logic         kin_ready,
    input  logic [127:0] kin,
    output logic         kout_valid,
    input  logic         kout_ready,
    output logic [127:0] kout,
    output logic [3:0]   kout_round,
    output logic         kout_last,
    output logic         busy
);

    ks_state_e    state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   round_q, round_d;

    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_p0, w_p1, w_p2, w_p3;
    logic [31:0]  w_rot, w_t;
    logic [127:0] w_prev;

    assign w_w0 = key_q[127:96];
    assign w_w1 = key_q[95:64];
    assign w_w2 = key_q[63:32];
    assign w_w3 = key_q[31:0];

    // Undo the forward word chain from the tail, then recover w0 through the g() term.
    assign w_p3  = xor_word(w_w3, w_w2);
    assign w_p2  = xor_word(w_w2, w_w1);
    assign w_p1  = xor_word(w_w1, w_w0);
    assign w_rot = rot_word(w_p3);

    genvar g;
    for (g = 0; g < 4; g++) begin : g_sbox
        S_Box u_sbox (
            .data_i (w_rot[8*g +: 8]),
            .data_o (w_t[8*g +: 8])
        );
    end

    assign w_p0   = xor_word(xor_word(w_w0, w_t), {rcon(round_q), 24'h000000});
    assign w_prev = {w_p0, w_p1, w_p2, w_p3};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        round_d    = round_q;
        kin_ready  = 1'b0;
        kout_valid = 1'b0;
        kout       = '0;
        kout_round = '0;
        kout_last  = 1'b0;
        busy       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                kin_ready = 1'b1;
                if (kin_valid) begin
                    key_d   = kin;
                    round_d = 4'(NR);
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                busy       = 1'b1;
                kout_valid = 1'b1;
                kout       = key_q;
                kout_round = round_q;
                kout_last  = (round_q == 4'd0);
                if (kout_ready) begin
                    if (round_q == 4'd0) begin
                        state_d = ST_IDLE;
                        key_d   = '0;
                        round_d = '0;
                    end else begin
                        key_d   = w_prev;
                        round_d = round_q - 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_inv_key_schedule.sv
// +-----------------------------------------------------------------------+
// | tb_inv_key_schedule : scoreboard bench, GF(2^8)-derived forward model  |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_inv_key_schedule;

    logic         clk = 1'b0;
    logic         rst;
    logic         kin_valid;
    logic         kin_ready;
    logic [127:0] kin;
    logic         kout_valid;
    logic         kout_ready;
    logic [127:0] kout;
    logic [3:0]   kout_round;
    logic         kout_last;
    logic         busy;

    always #5 clk = ~clk;

    inv_key_schedule dut (
        .clk        (clk),
        .rst        (rst),
        .kin_valid  (kin_valid),
        .kin_ready  (kin_ready),
        .kin        (kin),
        .kout_valid (kout_valid),
        .kout_ready (kout_ready),
        .kout       (kout),
        .kout_round (kout_round),
        .kout_last  (kout_last),
        .busy       (busy)
    );

    typedef struct packed {
        logic [127:0] key;
        logic [3:0]   rnd;
        logic         last;
    } exp_t;

    exp_t         sb[$];
    int           errors = 0;
    int           checks = 0;
    logic [7:0]   sbox_m [256];
    logic [7:0]   rcon_m [11];
    logic [127:0] rk     [11];

    localparam int M_FIPS = 0, M_BP = 1, M_BUSY = 2, M_RAND = 3, M_RST = 4;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_model();
        logic [7:0] inv, b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sbox_m[x] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
        end
        rcon_m[0] = 8'h00;
        rcon_m[1] = 8'h01;
        for (int i = 2; i <= 10; i++) rcon_m[i] = gmul(rcon_m[i-1], 8'h02);
    endtask

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0)
                t = {sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]], sbox_m[t[31:24]]}
                    ^ {rcon_m[i/4], 24'h000000};
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic push_expected();
        exp_t e;
        for (int r = 10; r >= 0; r--) begin
            e.key  = rk[r];
            e.rnd  = 4'(r);
            e.last = (r == 0);
            sb.push_back(e);
        end
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " kin_ready"},  128'(kin_ready),  128'd1);
        chk({tag, " kout_valid"}, 128'(kout_valid), 128'd0);
        chk({tag, " kout"},       kout,             128'd0);
        chk({tag, " kout_round"}, 128'(kout_round), 128'd0);
        chk({tag, " kout_last"},  128'(kout_last),  128'd0);
        chk({tag, " busy"},       128'(busy),       128'd0);
    endtask

    // Monitor: every accepted output beat must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (kout_valid && kout_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got round %0d key %h, expected no beat", kout_round, kout);
            end else begin
                e = sb.pop_front();
                checks++;
                if (kout !== e.key || kout_round !== e.rnd || kout_last !== e.last) begin
                    errors++;
                    $display("FAIL beat: got key %h round %0d last %b expected key %h round %0d last %b",
                             kout, kout_round, kout_last, e.key, e.rnd, e.last);
                end
            end
        end
    end

    task automatic run_key(input logic [127:0] k10, input int mode);
        int  g;
        int  i;
        bit  reset_done;
        g = 0;
        while (!kin_ready && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        if (!kin_ready) chk("kin_ready_wait", 128'(kin_ready), 128'd1);
        kin        = k10;
        kin_valid  = 1'b1;
        kout_ready = 1'b0;
        push_expected();
        @(posedge clk); #1;
        kin_valid  = (mode == M_BUSY);
        i          = 0;
        reset_done = 1'b0;
        while (sb.size() > 0 && i < 200 && !reset_done) begin
            case (mode)
                M_RAND: kout_ready = 1'($urandom_range(0, 1));
                M_BP:   kout_ready = !(i >= 1 && i <= 3);
                default: kout_ready = 1'b1;
            endcase
            if (mode == M_FIPS) begin
                if (i == 0)  chk("fips_r10", kout, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
                if (i == 1)  chk("fips_r9",  kout, 128'hac7766f319fadc2128d12941575c006e);
                if (i == 9)  chk("fips_r1",  kout, 128'ha0fafe1788542cb123a339392a6c7605);
                if (i == 10) chk("fips_r0",  kout, 128'h2b7e151628aed2a6abf7158809cf4f3c);
                if (i == 10) chk("fips_last", 128'(kout_last), 128'd1);
            end
            if (mode == M_BP && i >= 1 && i <= 3) begin
                chk("bp_hold_key",   kout,             128'hac7766f319fadc2128d12941575c006e);
                chk("bp_hold_round", 128'(kout_round), 128'd9);
            end
            if (mode == M_BP && i == 5) begin
                chk("bp_resume_key",   kout,             rk[8]);
                chk("bp_resume_round", 128'(kout_round), 128'd8);
            end
            if (mode == M_BUSY) begin
                kin = {$urandom(), $urandom(), $urandom(), $urandom()};
                chk("busy_kin_ready", 128'(kin_ready), 128'd0);
            end
            if (mode == M_RST && kout_valid && kout_round == 4'd5) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                kout_ready = 1'b0;
                sb.delete();
                chk_reset_outputs("midrst");
                reset_done = 1'b1;
            end else begin
                @(posedge clk); #1;
                i++;
            end
        end
        kin_valid  = 1'b0;
        kout_ready = 1'b0;
        if (sb.size() > 0) begin
            chk("sequence_timeout", 128'(sb.size()), 128'd0);
            sb.delete();
        end
        if (!reset_done) chk("kin_ready_after", 128'(kin_ready), 128'd1);
    endtask

    initial begin
        logic [127:0] key;
        rst        = 1'b1;
        kin_valid  = 1'b0;
        kin        = '0;
        kout_ready = 1'b0;
        build_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_outputs("reset");

        expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        run_key(rk[10], M_FIPS);
        run_key(rk[10], M_BP);
        run_key(rk[10], M_BUSY);
        run_key(rk[10], M_RST);
        run_key(rk[10], M_FIPS);

        for (int n = 0; n < 1000; n++) begin
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            expand(key);
            chk("model_round0", rk[0], key);
            run_key(rk[10], M_RAND);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 128'(sb.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
